// File: rtl/id_stage_if.sv
// Bundle of fetch, hazard, writeback and decode signals around the ID stage.
// The master side drives fetch/EX/WB inputs; the slave side is id_stage.
interface id_stage_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10
);
    logic [WORD_SIZE-1:0] if_instr;
    logic [ADDR_SIZE-1:0] if_pc;
    logic                 flush;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 wb_we;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;

    logic                 stall;
    logic                 id_valid;
    logic [ADDR_SIZE-1:0] id_pc;
    logic [WORD_SIZE-1:0] id_instr;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [WORD_SIZE-1:0] rs1_data;
    logic [WORD_SIZE-1:0] rs2_data;
    logic [WORD_SIZE-1:0] imm;

    modport master (
        output if_instr, if_pc, flush, ex_mem_read, ex_rd, wb_we, wb_rd, wb_data,
        input  stall, id_valid, id_pc, id_instr, rs1, rs2, rd, rs1_data, rs2_data, imm
    );

    modport slave (
        input  if_instr, if_pc, flush, ex_mem_read, ex_rd, wb_we, wb_rd, wb_data,
        output stall, id_valid, id_pc, id_instr, rs1, rs2, rd, rs1_data, rs2_data, imm
    );
endinterface

// File: rtl/id_stage.sv
// RISC-V decode stage: IF/ID register, load-use hazard detect, register file, immediates.
// Optional macro ID_BYPASS_EN forwards the same-cycle writeback value to rs1/rs2 reads.
module id_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input logic     clk,
    input logic     rst,
    id_stage_if.slave bus
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [WORD_SIZE-1:0] instr_q;
    logic [ADDR_SIZE-1:0] pc_q;
    logic                 valid_q;

    logic [WORD_SIZE-1:0] regs [32];

    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 stall;
    logic [WORD_SIZE-1:0] rs1_raw;
    logic [WORD_SIZE-1:0] rs2_raw;
    logic [WORD_SIZE-1:0] rs1_data;
    logic [WORD_SIZE-1:0] rs2_data;
    logic [31:0]          imm32;
    logic                 wb_hit_ok;

    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    assign stall = valid_q && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                   ((bus.ex_rd == rs1) || (bus.ex_rd == rs2));

    // Flush wins over stall so a taken branch always squashes the wrong-path instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= WORD_SIZE'(NOP_INSTR);
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (bus.flush) begin
            instr_q <= WORD_SIZE'(NOP_INSTR);
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            instr_q <= bus.if_instr;
            pc_q    <= bus.if_pc;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_we && (bus.wb_rd != 5'd0)) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign rs1_raw   = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_raw   = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign wb_hit_ok = bus.wb_we && (bus.wb_rd != 5'd0);

`ifdef ID_BYPASS_EN
    always_comb begin
        rs1_data = rs1_raw;
        rs2_data = rs2_raw;
        if (wb_hit_ok && (bus.wb_rd == rs1)) begin
            rs1_data = bus.wb_data;
        end
        if (wb_hit_ok && (bus.wb_rd == rs2)) begin
            rs2_data = bus.wb_data;
        end
    end
`else
    // Without bypass, a same-cycle write becomes visible only after the edge.
    logic unused_wb_hit;
    assign unused_wb_hit = wb_hit_ok;
    always_comb begin
        rs1_data = rs1_raw;
        rs2_data = rs2_raw;
    end
`endif

    always_comb begin
        imm32 = 32'h0;
        case (instr_q[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
            OP_STORE:
                imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                         instr_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr_q[31:12], 12'h000};
            OP_JAL:
                imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                         instr_q[30:21], 1'b0};
            default:
                imm32 = 32'h0;
        endcase
    end

    assign bus.stall    = stall;
    assign bus.id_valid = valid_q && !stall;
    assign bus.id_pc    = pc_q;
    assign bus.id_instr = instr_q;
    assign bus.rs1      = rs1;
    assign bus.rs2      = rs2;
    assign bus.rd       = instr_q[11:7];
    assign bus.rs1_data = rs1_data;
    assign bus.rs2_data = rs2_data;
    assign bus.imm      = WORD_SIZE'($signed(imm32));

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage; expected values are hand-decoded RISC-V encodings.
module tb_id_stage;

    localparam int          WORD_SIZE = 32;
    localparam int          ADDR_SIZE = 10;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] ADDI_X1   = 32'h0050_0093;
    localparam logic [31:0] ADD_X3    = 32'h0011_01B3;
    localparam logic [31:0] ADD_X4    = 32'h0020_8233;
    localparam logic [31:0] BEQ_M8    = 32'hFE00_0CE3;
    localparam logic [31:0] ADD_X6_X5 = 32'h0002_8333;

    logic clk;
    logic rst;
    int   checkCount = 0;
    int   errorCount = 0;

    id_stage_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

    id_stage #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [9:0] pc,
                                 input logic fl, input logic memRead, input logic [4:0] exRd);
        bus.if_instr    = instr;
        bus.if_pc       = pc;
        bus.flush       = fl;
        bus.ex_mem_read = memRead;
        bus.ex_rd       = exRd;
        #1;
    endtask

    task automatic applyWriteback(input logic we, input logic [4:0] rd, input logic [31:0] data);
        bus.wb_we   = we;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] immInstr [8] = '{32'hFFF0_0093, 32'hFE11_2E23, 32'h1234_52B7, 32'hFFDF_F06F,
                                  32'h0002_8333, 32'h0000_0073, 32'h0080_80E7, 32'h0000_1097};
    logic [31:0] immExp   [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h1234_5000, 32'hFFFF_FFFC,
                                  32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 32'h0000_1000};

    initial begin
        rst = 1'b0;
        applyStimulus(32'h0, 10'h0, 1'b0, 1'b0, 5'd0);
        applyWriteback(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #2;
        checkOutput("rst_stall",    32'(bus.stall),    32'h0);
        checkOutput("rst_id_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("rst_id_pc",    32'(bus.id_pc),    32'h0);
        checkOutput("rst_id_instr", bus.id_instr,      NOP);
        checkOutput("rst_imm",      bus.imm,           32'h0);
        checkOutput("rst_rs1_data", bus.rs1_data,      32'h0);
        checkOutput("rst_rs2_data", bus.rs2_data,      32'h0);
        applyStimulus(ADDI_X1, 10'h004, 1'b0, 1'b0, 5'd0);
        tick();
        checkOutput("rst_hold_instr", bus.id_instr, NOP);
        @(negedge clk);
        rst = 1'b0;

        // First capture after reset release.
        applyStimulus(ADDI_X1, 10'h004, 1'b0, 1'b0, 5'd0);
        tick();
        checkOutput("addi_valid", 32'(bus.id_valid), 32'h1);
        checkOutput("addi_rd",    32'(bus.rd),       32'd1);
        checkOutput("addi_rs1",   32'(bus.rs1),      32'd0);
        checkOutput("addi_imm",   bus.imm,           32'h0000_0005);
        checkOutput("addi_pc",    32'(bus.id_pc),    32'h004);

        // Load-use hazard: exactly one held cycle.
        applyStimulus(ADD_X3, 10'h008, 1'b0, 1'b0, 5'd0);
        tick();
        checkOutput("add_rs1", 32'(bus.rs1), 32'd2);
        checkOutput("add_rs2", 32'(bus.rs2), 32'd1);
        checkOutput("add_rd",  32'(bus.rd),  32'd3);
        applyStimulus(ADD_X4, 10'h00C, 1'b0, 1'b1, 5'd1);
        checkOutput("hz_rs2_stall", 32'(bus.stall), 32'h1);
        applyStimulus(ADD_X4, 10'h00C, 1'b0, 1'b1, 5'd5);
        checkOutput("hz_nomatch_stall", 32'(bus.stall), 32'h0);
        applyStimulus(ADD_X4, 10'h00C, 1'b0, 1'b0, 5'd2);
        checkOutput("hz_noload_stall", 32'(bus.stall), 32'h0);
        applyStimulus(ADD_X4, 10'h00C, 1'b0, 1'b1, 5'd2);
        checkOutput("hz_rs1_stall", 32'(bus.stall),    32'h1);
        checkOutput("hz_id_valid",  32'(bus.id_valid), 32'h0);
        tick();
        checkOutput("hz_hold_instr", bus.id_instr,   ADD_X3);
        checkOutput("hz_hold_pc",    32'(bus.id_pc), 32'h008);
        applyStimulus(ADD_X4, 10'h00C, 1'b0, 1'b0, 5'd0);
        checkOutput("hz_release_stall", 32'(bus.stall),    32'h0);
        checkOutput("hz_release_valid", 32'(bus.id_valid), 32'h1);
        tick();
        checkOutput("hz_next_instr", bus.id_instr,   ADD_X4);
        checkOutput("hz_next_pc",    32'(bus.id_pc), 32'h00C);

        // Branch immediate, then flush squashes IF/ID.
        applyStimulus(BEQ_M8, 10'h010, 1'b0, 1'b0, 5'd0);
        tick();
        checkOutput("beq_imm", bus.imm, 32'hFFFF_FFF8);
        applyStimulus(ADD_X4, 10'h014, 1'b1, 1'b0, 5'd0);
        tick();
        checkOutput("flush_instr", bus.id_instr,      NOP);
        checkOutput("flush_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("flush_pc",    32'(bus.id_pc),    32'h0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(immInstr[i], 10'(32'h40 + i * 4), 1'b0, 1'b0, 5'd0);
            tick();
            checkOutput($sformatf("imm_vec%0d", i), bus.imm, immExp[i]);
        end

        // Register file: writes, then distinct operand reads.
        applyWriteback(1'b1, 5'd1, 32'h0000_0022);
        tick();
        applyWriteback(1'b1, 5'd2, 32'h0000_0011);
        tick();
        applyWriteback(1'b0, 5'd0, 32'h0);
        applyStimulus(ADD_X3, 10'h070, 1'b0, 1'b0, 5'd0);
        tick();
        checkOutput("rf_rs1_data", bus.rs1_data, 32'h0000_0011);
        checkOutput("rf_rs2_data", bus.rs2_data, 32'h0000_0022);

        applyStimulus(ADD_X6_X5, 10'h080, 1'b0, 1'b0, 5'd0);
        tick();
        applyWriteback(1'b1, 5'd5, 32'hDEAD_BEEF);
`ifdef ID_BYPASS_EN
        checkOutput("wb_same_cycle", bus.rs1_data, 32'hDEAD_BEEF);
`else
        checkOutput("wb_same_cycle", bus.rs1_data, 32'h0000_0000);
`endif
        tick();
        applyWriteback(1'b0, 5'd0, 32'h0);
        checkOutput("wb_after_edge", bus.rs1_data, 32'hDEAD_BEEF);
        applyWriteback(1'b1, 5'd0, 32'h0000_1234);
        tick();
        applyWriteback(1'b0, 5'd0, 32'h0);
        checkOutput("x0_read", bus.rs2_data, 32'h0);

        // Flush and stall together: flush wins.
        applyStimulus(ADD_X3, 10'h090, 1'b0, 1'b0, 5'd0);
        tick();
        applyStimulus(ADD_X4, 10'h094, 1'b1, 1'b1, 5'd2);
        checkOutput("fs_stall_before", 32'(bus.stall), 32'h1);
        tick();
        checkOutput("fs_instr", bus.id_instr,      NOP);
        checkOutput("fs_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("fs_stall", 32'(bus.stall),    32'h0);

        // Reset pulse in the middle of a stall.
        applyStimulus(ADD_X3, 10'h0A0, 1'b0, 1'b0, 5'd0);
        tick();
        applyStimulus(ADDI_X1, 10'h0A4, 1'b0, 1'b1, 5'd1);
        checkOutput("mr_stall_before", 32'(bus.stall), 32'h1);
        checkOutput("mr_rs1_before",   bus.rs1_data,   32'h0000_0011);
        rst = 1'b1;
        #1;
        checkOutput("mr_instr",    bus.id_instr,    NOP);
        checkOutput("mr_rs1_data", bus.rs1_data,    32'h0);
        checkOutput("mr_stall",    32'(bus.stall),  32'h0);
        rst = 1'b0;
        #1;
        checkOutput("mr_stall_released", 32'(bus.stall), 32'h0);
        tick();
        checkOutput("mr_first_pc",    32'(bus.id_pc),    32'h0A4);
        checkOutput("mr_first_valid", 32'(bus.id_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
